// File: rtl/pc_control_if.sv
// Bundle of control inputs and fetch-side outputs for the PC control block.
// The master side (pipeline / bench) drives stall and the redirect requests;
// the slave side (pc_control) drives the fetch address and status pulses.
interface pc_control_if #(
  parameter int CNT_W = 16
);

  // Hazard and redirect requests
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              jump;
  logic [31:0]       jump_target;

  // Registered fetch-side outputs
  logic [31:0]       pc;
  logic              nop;
  logic              fetch_valid;
  logic              misaligned;
  logic [CNT_W-1:0]  redirect_count;

  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_target,
    input  pc,
    input  nop,
    input  fetch_valid,
    input  misaligned,
    input  redirect_count
  );

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_target,
    output pc,
    output nop,
    output fetch_valid,
    output misaligned,
    output redirect_count
  );

endinterface

// File: rtl/pc_control.sv
// Program-counter control for a simple in-order pipeline.
// Sequential fetch advances by 4. A taken EX-stage branch or an ID-stage jump
// redirects fetch, emits a one-cycle nop to flush the downstream PC pipeline,
// and enters FLUSH, where the PC is held for one cycle before fetch resumes.
// Every output is registered, so no input reaches an output combinationally.
module pc_control #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  pc_control_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             nop_q, nop_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             redirect;
  logic [31:0]      target;

  // Redirect request decode; the branch wins because it belongs to the older
  // instruction, so a younger jump in the same cycle is on the wrong path.
  always_comb begin
    redirect = bus.branch_taken | bus.jump;
    target   = bus.branch_taken ? bus.branch_target : bus.jump_target;
  end

  // Next-state and next-output logic for the RUN/FLUSH machine.
  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    nop_d         = 1'b0;
    fetch_valid_d = 1'b0;
    misaligned_d  = 1'b0;
    cnt_d         = cnt_q;

    if (redirect) begin
      // Redirect beats stall in both states; a redirect while already in
      // FLUSH simply restarts the flush at the newer target.
      pc_d          = {target[31:2], 2'b00};
      nop_d         = 1'b1;
      fetch_valid_d = 1'b1;
      misaligned_d  = |target[1:0];
      state_d       = FLUSH;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (!bus.stall) begin
            // Sequential fetch; natural 32-bit wrap at the top of memory.
            pc_d          = pc_q + 32'd4;
            fetch_valid_d = 1'b1;
          end
        end
        FLUSH: begin
          // Downstream ignores the cycle after the nop, so hold the PC once
          // and resume sequential fetch next cycle whatever stall says.
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset; reset abandons any
  // flush in progress so no nop pulse follows reset release.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      nop_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      nop_q         <= nop_d;
      fetch_valid_q <= fetch_valid_d;
      misaligned_q  <= misaligned_d;
      cnt_q         <= cnt_d;
    end
  end

  // Drive the interface straight from the registers.
  always_comb begin
    bus.pc             = pc_q;
    bus.nop            = nop_q;
    bus.fetch_valid    = fetch_valid_q;
    bus.misaligned     = misaligned_q;
    bus.redirect_count = cnt_q;
  end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16: width of the redirect counter.
REQ-003 clk  input  1  processor main clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hazard stall; hold the current PC.
REQ-006 branch_taken  input  1  EX-stage branch resolved taken.
REQ-007 branch_target  input  32  EX-stage branch destination.
REQ-008 jump  input  1  ID-stage unconditional jump (JAL/JALR).
REQ-009 jump_target  input  32  ID-stage jump destination.
REQ-010 pc  output  32  registered fetch address; also drives the downstream PC pipeline input.
REQ-011 nop  output  1  registered flush pulse to the downstream PC pipeline.
REQ-012 fetch_valid  output  1  registered; high when pc is a new address to fetch this cycle.
REQ-013 misaligned  output  1  registered one-cycle pulse: accepted target had bits [1:0] != 0.
REQ-014 redirect_count  output  CNT_W  saturating count of accepted redirects.

Function
REQ-015 SHALL implement a two-state FSM: RUN and FLUSH.
REQ-016 SHALL treat redirect = branch_taken | jump.
- branch_taken has priority over jump: it belongs to the older instruction.
REQ-017 SHALL define the selected target as branch_target if branch_taken, else jump_target.
- Bits [1:0] of the selected target are forced to 2'b00 before loading.
REQ-018 RUN, redirect: pc <= target; nop <= 1; fetch_valid <= 1; state <= FLUSH.
REQ-019 RUN, no redirect, stall=1: pc holds; nop <= 0; fetch_valid <= 0; state stays RUN.
REQ-020 RUN, no redirect, stall=0: pc <= pc + 4 (32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000); nop <= 0; fetch_valid <= 1.
REQ-021 FLUSH, no redirect: pc holds (downstream ignores one cycle after nop); nop <= 0; fetch_valid <= 0; state <= RUN, regardless of stall.
REQ-022 FLUSH, redirect: behaves as REQ-018 (new target loaded, nop re-asserted), state stays FLUSH.
REQ-023 SHALL give redirect priority over stall in both states.
REQ-024 misaligned <= 1 for exactly the cycle after accepting a target with nonzero [1:0]; else 0.
REQ-025 redirect_count SHALL increment by 1 per accepted redirect and saturate at all-ones (no wrap).
REQ-026 Latency: every input affects outputs only after the next rising clk edge; no combinational input-to-output path.
REQ-027 nop SHALL never be high on two consecutive cycles unless a redirect is accepted in each of those cycles.

Reset
REQ-028 rst_n low SHALL immediately, without a clock, set:
- pc = RESET_VECTOR; nop = 0; fetch_valid = 0; misaligned = 0; redirect_count = 0; state = RUN.
REQ-029 Reset asserted mid-FLUSH SHALL abandon the flush; no nop pulse follows reset release.
REQ-030 First rising edge after rst_n rises, with no stall or redirect: pc = RESET_VECTOR + 4, fetch_valid = 1.

Verification
REQ-031 Sequential fetch: reset, release, 3 free cycles -> pc 0x4, 0x8, 0xC; nop = 0 throughout.
REQ-032 Branch vs jump, same cycle: branch_taken=1 to 0x100, jump=1 to 0x200 ->
- pc = 0x100, nop = 1 for one cycle, then pc holds 0x100 one cycle, then 0x104;
- redirect_count = 1.
REQ-033 Stall/redirect interaction:
- stall=1 for 2 cycles at pc 0x20 -> pc stays 0x20, fetch_valid = 0;
- stall=1 with jump to 0x40 -> pc = 0x40, nop = 1.
REQ-034 Back-to-back redirect in FLUSH: jump 0x80, then next cycle branch 0x300 ->
- pc 0x80 then 0x300; nop high both cycles;
- pc holds 0x300 one cycle, then 0x304.
REQ-035 Misaligned target and wrap:
- jump to 0x103 -> pc = 0x100, misaligned one-cycle pulse;
- separately, redirect to 0xFFFF_FFFC -> after flush cycle, pc = 0x0.
REQ-036 Counter and async reset:
- with CNT_W=2, 5 redirects -> redirect_count = 3;
- rst_n pulsed low between clock edges during FLUSH -> all outputs at reset values immediately.
